// File: rtl/cpu_dbg_pkg.sv
// Shared types and constants for the CPU run/dump debug controller.
package cpu_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_RD,
    ST_TX,
    ST_DONE
  } state_e;

  // Reason the last run stopped: bit0 = cycle limit, bit1 = halt.
  localparam logic [1:0] STOP_NONE = 2'b00;
  localparam logic [1:0] STOP_CNT  = 2'b01;
  localparam logic [1:0] STOP_HALT = 2'b10;
  localparam logic [1:0] STOP_BOTH = 2'b11;

endpackage

// File: rtl/cpu_run_dump_ctrl_counter.sv
// Saturating run-cycle counter with a terminal flag one cycle before END_COUNT.
module run_cycle_counter #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned END_COUNT = 25
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             term_o
);

  // END_COUNT of zero disables the limit; TERM_VAL is then unused.
  localparam bit               LIMIT_EN = (END_COUNT != 0);
  localparam logic [CNT_W-1:0] TERM_VAL = LIMIT_EN ? CNT_W'(END_COUNT - 1) : '0;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise increment until all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = LIMIT_EN && (cnt_q == TERM_VAL);

endmodule

// File: rtl/cpu_run_dump_ctrl.sv
// Run controller: enables the CPU for a bounded run, then streams the
// first NUM_REGS register-file entries over a valid/ready port.
module cpu_run_dump_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_REGS  = 13,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned END_COUNT = 25,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              halt_i,
  output logic              cpu_run_o,
  output logic [ADDR_W-1:0] rf_addr_o,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [ADDR_W-1:0] dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              dump_last_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic [1:0]        stop_cause_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] beat_idx_q, beat_idx_d;
  logic [DATA_W-1:0] beat_data_q, beat_data_d;
  logic              beat_last_q, beat_last_d;
  logic [1:0]        stop_cause_q, stop_cause_d;
  logic              cnt_clr, cnt_en, cnt_term;

  run_cycle_counter #(
    .CNT_W    (CNT_W),
    .END_COUNT(END_COUNT)
  ) u_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cycle_cnt_o),
    .term_o(cnt_term)
  );

  // Sequencing: IDLE/DONE -> RUN -> (RD -> TX) x NUM_REGS -> DONE.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    beat_idx_d   = beat_idx_q;
    beat_data_d  = beat_data_q;
    beat_last_d  = beat_last_q;
    stop_cause_d = stop_cause_q;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          cnt_clr      = 1'b1;
          stop_cause_d = STOP_NONE;
          idx_d        = '0;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        // The stopping cycle still counts as a run cycle.
        cnt_en = 1'b1;
        if (halt_i || cnt_term) begin
          if (halt_i && cnt_term) begin
            stop_cause_d = STOP_BOTH;
          end else if (halt_i) begin
            stop_cause_d = STOP_HALT;
          end else begin
            stop_cause_d = STOP_CNT;
          end
          idx_d   = '0;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        beat_data_d = rf_data_i;
        beat_idx_d  = idx_q;
        beat_last_d = (idx_q == LAST_IDX);
        state_d     = ST_TX;
      end
      ST_TX: begin
        if (dump_ready_i) begin
          if (beat_last_q) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_RD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and dump datapath registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      beat_idx_q   <= '0;
      beat_data_q  <= '0;
      beat_last_q  <= 1'b0;
      stop_cause_q <= STOP_NONE;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      beat_idx_q   <= beat_idx_d;
      beat_data_q  <= beat_data_d;
      beat_last_q  <= beat_last_d;
      stop_cause_q <= stop_cause_d;
    end
  end

  assign cpu_run_o    = (state_q == ST_RUN);
  assign dump_valid_o = (state_q == ST_TX);
  assign done_o       = (state_q == ST_DONE);
  assign rf_addr_o    = idx_q;
  assign dump_idx_o   = beat_idx_q;
  assign dump_data_o  = beat_data_q;
  assign dump_last_o  = beat_last_q;
  assign stop_cause_o = stop_cause_q;

endmodule
